// File: rtl/nb_gf5_pkg.sv
// Shared GF(2^5) normal-basis definitions: field degree, FSM states,
// squaring (a cyclic rotation in normal basis) and the unity element.
package nb_gf5_pkg;

  localparam int M = 5;

  // Normal-basis unity: every coordinate set.
  localparam logic [M-1:0] ONE = 5'b11111;

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    DONE
  } state_t;

  function automatic logic [M-1:0] sq(input logic [M-1:0] x);
    return {x[M-2:0], x[M-1]};
  endfunction

endpackage

// File: rtl/nb_inv_if.sv
// Operand/result handshake bundle for the normal-basis inverter.
interface nb_inv_if
  import nb_gf5_pkg::*;
;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] A;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] Z;
  logic         out_zero;

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, Z, out_zero
  );

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, Z, out_zero
  );
endinterface

// File: rtl/nb_comb.sv
// Per-iteration product bits of the serial GF(2^5) normal-basis multiplier.
// Produces the three z bits that change each iteration; the remaining bits
// are a plain shift of the accumulator.
module nb_comb (
  input  logic a0,
  input  logic a1,
  input  logic a4,
  input  logic b0,
  input  logic b1,
  input  logic b4,
  input  logic z2,
  input  logic z3,
  input  logic z4,
  output logic r0,
  output logic r3,
  output logic r4
);
  logic c1, c2, c3, c4;
  logic d0, d1, d2;

  assign c1 = a0 ^ a4;
  assign c2 = b0 ^ b4;
  assign c3 = a1 ^ a4;
  assign c4 = b1 ^ b4;

  assign d0 = a4 & b4;
  assign d1 = c1 & c2;
  assign d2 = c3 & c4;

  assign r0 = d0 ^ d1 ^ z4;
  assign r3 = d1 ^ d2 ^ z2;
  assign r4 = d2 ^ z3;
endmodule

// File: rtl/nb_inv.sv
// Bit-serial GF(2^5) normal-basis inverter, Z = A^30 by Itoh-Tsujii:
// t1 = A^2 * A, t2 = t1^4 * t1, Z = t2^2. Squarings are rotations, so the
// only real work is two 5-cycle serial products on one shared multiplier.
//
//  state | meaning
//  IDLE  | ready for an operand
//  MUL1  | serial product A^2 * A        (cnt = iteration)
//  MUL2  | serial product t1^4 * t1      (cnt = iteration)
//  DONE  | result presented, waiting for out_ready
module nb_inv
  import nb_gf5_pkg::*;
#(
  parameter int M = 5
) (
  input  logic       clk,
  input  logic       rst,
  nb_inv_if.slave    bus
);

  if (M != 5) begin : g_bad_m
    $error("nb_inv: product logic is hard-wired for M = 5");
  end

  localparam logic [2:0] CNT_LAST = 3'd4;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [4:0] a, a_nxt;
  logic [4:0] b, b_nxt;
  logic [4:0] z, z_nxt;
  logic [4:0] res, res_nxt;
  logic       zero_r, zero_nxt;
  logic [4:0] p;
  logic       r0, r3, r4;

  nb_comb u_comb (
    .a0(a[0]), .a1(a[1]), .a4(a[4]),
    .b0(b[0]), .b1(b[1]), .b4(b[4]),
    .z2(z[2]), .z3(z[3]), .z4(z[4]),
    .r0(r0),   .r3(r3),   .r4(r4)
  );

  // Accumulator value after the current iteration.
  assign p = {r4, r3, z[1], z[0], r0};

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      z      <= '0;
      res    <= '0;
      zero_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      z      <= z_nxt;
      res    <= res_nxt;
      zero_r <= zero_nxt;
    end
  end

  // Next-state and datapath sequencing for the two chained products.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    z_nxt     = z;
    res_nxt   = res;
    zero_nxt  = zero_r;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_nxt     = sq(bus.A);
          b_nxt     = bus.A;
          z_nxt     = '0;
          cnt_nxt   = '0;
          zero_nxt  = (bus.A == '0);
          state_nxt = MUL1;
        end
      end
      MUL1: begin
        if (cnt == CNT_LAST) begin
          a_nxt     = sq(sq(p));
          b_nxt     = p;
          z_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = MUL2;
        end else begin
          a_nxt   = sq(a);
          b_nxt   = sq(b);
          z_nxt   = p;
          cnt_nxt = cnt + 3'd1;
        end
      end
      MUL2: begin
        if (cnt == CNT_LAST) begin
          res_nxt   = sq(p);
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          a_nxt   = sq(a);
          b_nxt   = sq(b);
          z_nxt   = p;
          cnt_nxt = cnt + 3'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Z         = res;
  assign bus.out_zero  = zero_r;

endmodule

// File: tb/tb_nb_inv.sv
// Self-checking bench for nb_inv. Expected inverses come from a brute-force
// search over the field using a behavioural multiply, not from the
// exponentiation chain the design uses.
module tb_nb_inv;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] REF_ONE = 5'b11111;

  nb_inv_if bus ();

  nb_inv #(.M(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] rot(input logic [4:0] x);
    return {x[3:0], x[4]};
  endfunction

  // Field product from the serial normal-basis definition.
  function automatic logic [4:0] ref_mul(input logic [4:0] x, input logic [4:0] y);
    logic [4:0] ra, rb, rz;
    logic c1, c2, c3, c4, d0, d1, d2;
    ra = x; rb = y; rz = '0;
    for (int i = 0; i < 5; i++) begin
      c1 = ra[0] ^ ra[4]; c2 = rb[0] ^ rb[4];
      c3 = ra[1] ^ ra[4]; c4 = rb[1] ^ rb[4];
      d0 = ra[4] & rb[4]; d1 = c1 & c2; d2 = c3 & c4;
      rz = {d2 ^ rz[3], d1 ^ d2 ^ rz[2], rz[1], rz[0], d0 ^ d1 ^ rz[4]};
      ra = rot(ra); rb = rot(rb);
    end
    return rz;
  endfunction

  // Inverse by exhaustive search for y with y*x = 1; zero maps to zero.
  function automatic logic [4:0] ref_inv(input logic [4:0] x);
    logic [4:0] y;
    if (x == '0) return '0;
    for (int k = 1; k < 32; k++) begin
      y = k[4:0];
      if (ref_mul(y, x) == REF_ONE) return y;
    end
    return '0;
  endfunction

  // One full transaction: accept, measure latency, optionally stall in DONE.
  task automatic run_op(input logic [4:0] av, input int hold,
                        output logic [4:0] zr, output logic zz);
    int n;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.A         = av;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = 5'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      chk("in_ready_busy", bus.in_ready, 0);
      n++;
      @(negedge clk);
    end
    chk("latency", n, 10);
    zr = bus.Z;
    zz = bus.out_zero;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = 5'($urandom);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_z", bus.Z, zr);
      chk("hold_zero", bus.out_zero, zz);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_ready", bus.in_ready, 1);
    chk("post_hs_valid", bus.out_valid, 0);
  endtask

  // Accept an operand and stop at the negedge n cycles after the accept edge.
  task automatic start_and_wait(input logic [4:0] av, input int n);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = av;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset_check(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_ready"}, bus.in_ready, 1);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_z"}, bus.Z, 0);
    chk({tag, "_zero"}, bus.out_zero, 0);
  endtask

  logic [4:0] zd [32];
  logic [4:0] zr, av, a1, a2;
  logic       zz;
  logic [4:0] b2b_res [2];
  int         acc, busy, nres, s;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_z", bus.Z, 0);
    chk("rst_zero", bus.out_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // Unity and zero.
    run_op(REF_ONE, 0, zr, zz);
    chk("one_z", zr, REF_ONE);
    chk("one_zero", zz, 0);
    run_op(5'b00000, 0, zr, zz);
    chk("zero_z", zr, 0);
    chk("zero_flag", zz, 1);

    // Every nonzero operand, random order and random backpressure.
    zd[0] = '0;
    s = $urandom_range(0, 30);
    for (int k = 0; k < 31; k++) begin
      av = 5'(((k + s) % 31) + 1);
      run_op(av, $urandom_range(0, 3), zr, zz);
      zd[av] = zr;
      chk("sweep_inv", zr, ref_inv(av));
      chk("sweep_mul_one", ref_mul(zr, av), REF_ONE);
      chk("sweep_zero", zz, 0);
    end
    for (int k = 1; k < 32; k++) begin
      av = 5'(k);
      chk("sq_commute", zd[rot(av)], rot(zd[av]));
      chk("involution", zd[zd[av]], av);
    end

    // Long stall in DONE.
    av = 5'($urandom_range(1, 31));
    run_op(av, 7, zr, zz);
    chk("stall_inv", zr, ref_inv(av));

    // Random operands including zero.
    for (int k = 0; k < 12; k++) begin
      av = 5'($urandom);
      if (k == 5) av = '0;
      run_op(av, $urandom_range(0, 2), zr, zz);
      chk("rand_inv", zr, ref_inv(av));
      chk("rand_zero", zz, (av == '0));
    end

    // Reset in MUL1 with cnt = 2 (third cycle after accept).
    start_and_wait(5'($urandom_range(1, 31)), 3);
    pulse_reset_check("rst_mul1");
    // Reset in MUL2 with cnt = 4 (tenth cycle after accept).
    run_op(5'b00110, 0, zr, zz);
    start_and_wait(5'($urandom_range(1, 31)), 10);
    chk("pre_rst_busy", bus.out_valid, 0);
    pulse_reset_check("rst_mul2");
    run_op(REF_ONE, 0, zr, zz);
    chk("post_rst_one", zr, REF_ONE);

    // Back-to-back with in_valid held high.
    a1 = 5'($urandom_range(1, 31));
    a2 = 5'($urandom_range(0, 31));
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.A         = a1;
    bus.out_ready = 1'b1;
    acc = 0; busy = 0; nres = 0;
    for (int c = 0; c < 60 && nres < 2; c++) begin
      if (acc == 2) bus.in_valid = 1'b0;
      if (acc == 1) bus.A = a2;
      if (bus.out_valid) begin
        b2b_res[nres] = bus.Z;
        nres++;
      end
      if (bus.in_ready && bus.in_valid) begin
        if (acc == 1) chk("b2b_gap", busy, 11);
        acc++;
      end else if (acc == 1) begin
        busy++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_results", nres, 2);
    chk("b2b_res0", b2b_res[0], ref_inv(a1));
    chk("b2b_res1", b2b_res[1], ref_inv(a2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
